// File: rtl/sraml_pkg.sv
// sraml_pkg: shared state encoding, transfer size codes and helpers for the SRAM-like bridge
package sraml_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sraml_wen2size.sv
// sraml_wen2size: converts a byte-strobe pattern into transfer size, byte offset and legality
//   i_strb   byte write strobes
//   o_size   log2 of the number of set strobes
//   o_offset byte index of the lowest set strobe
//   o_legal  strobe is one contiguous, naturally aligned group of 1/2/4/8 bytes
module sraml_wen2size
  import sraml_pkg::*;
#(
  parameter int STRB_W = 4
) (
  input  logic [STRB_W-1:0]        i_strb,
  output logic [1:0]               o_size,
  output logic [clog2(STRB_W)-1:0] o_offset,
  output logic                     o_legal
);
  localparam int OW = clog2(STRB_W);
  localparam logic [STRB_W-1:0] ONES = '1;
  int w_lo;
  int w_cnt;
  logic [STRB_W-1:0] w_pat;
  always_comb begin
    w_lo = 0;
    w_cnt = 0;
    for (int i = STRB_W - 1; i >= 0; i--) if (i_strb[i]) w_lo = i;
    for (int i = 0; i < STRB_W; i++) w_cnt += int'(i_strb[i]);
  end
  // The only legal pattern for this count/offset is a solid run of w_cnt ones starting at w_lo.
  assign w_pat = (ONES >> (STRB_W - w_cnt)) << w_lo;
  assign o_legal = (w_cnt != 0) && ((w_cnt & (w_cnt - 1)) == 0) &&
                   ((w_lo & (w_cnt - 1)) == 0) && (i_strb == w_pat);
  assign o_size = (w_cnt == 8) ? SIZE_DWORD : (w_cnt == 4) ? SIZE_WORD :
                  (w_cnt == 2) ? SIZE_HALF : SIZE_BYTE;
  assign o_offset = OW'(w_lo);
endmodule

// File: rtl/sram2sraml_bridge.sv
// sram2sraml_bridge: stall-based SRAM port to split-handshake SRAM-like bus bridge
//   i_clk/i_resetn                  clock, asynchronous active-low reset
//   i_sram_en/wen/addr/wdata        pipeline access request (held stable while o_stall)
//   o_sram_rdata, o_stall           captured read data, pipeline stall
//   i_longest_stall, i_flush        global stall hold, abandon current access
//   o_illegal_wen                   one-cycle pulse on a non-encodable strobe
//   o_req/wr/size/addr/wdata        SRAM-like request
//   i_addr_ok/i_data_ok/i_rdata     SRAM-like handshakes and read data
module sram2sraml_bridge
  import sraml_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int WRITE_EN = 1,
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_sram_en,
  input  logic [STRB_W-1:0] i_sram_wen,
  input  logic [ADDR_W-1:0] i_sram_addr,
  input  logic [DATA_W-1:0] i_sram_wdata,
  output logic [DATA_W-1:0] o_sram_rdata,
  output logic              o_stall,
  input  logic              i_longest_stall,
  input  logic              i_flush,
  output logic              o_illegal_wen,
  output logic              o_req,
  output logic              o_wr,
  output logic [1:0]        o_size,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic              i_addr_ok,
  input  logic              i_data_ok,
  input  logic [DATA_W-1:0] i_rdata
);
  localparam int OW = clog2(STRB_W);
  state_t r_state;
  state_t w_next;
  logic r_wr;
  logic r_illegal;
  logic [DATA_W-1:0] r_rdata;
  logic [STRB_W-1:0] w_wen;
  logic [1:0] w_wsize;
  logic [OW-1:0] w_off;
  logic w_strb_ok;
  logic w_wr;
  logic w_start;
  logic w_bad;
  logic w_load;
  assign w_wen = (WRITE_EN != 0) ? i_sram_wen : '0;
  assign w_wr = |w_wen;
  sraml_wen2size #(.STRB_W(STRB_W)) u_wen2size (
    .i_strb   (w_wen),
    .o_size   (w_wsize),
    .o_offset (w_off),
    .o_legal  (w_strb_ok)
  );
  assign w_start = i_sram_en & (r_state == S_IDLE) & ~i_flush;
  assign o_req = w_start & (~w_wr | w_strb_ok);
  assign w_bad = w_start & w_wr & ~w_strb_ok;
  assign o_wr = w_wr;
  assign o_size = w_wr ? w_wsize : 2'(OW);
  assign o_addr = w_wr ? {i_sram_addr[ADDR_W-1:OW], w_off} : i_sram_addr;
  assign o_wdata = (WRITE_EN != 0) ? i_sram_wdata : '0;
  assign o_stall = i_sram_en & (r_state != S_DONE) & ~i_flush;
  assign o_sram_rdata = r_rdata;
  assign o_illegal_wen = r_illegal;
  // Read data is captured only for a live read: same-cycle return in IDLE, or an unflushed return in WAIT.
  assign w_load = i_data_ok & ((o_req & ~w_wr) | ((r_state == S_WAIT) & ~i_flush & ~r_wr));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (o_req && i_addr_ok) ? (i_data_ok ? S_DONE : S_WAIT) : (w_bad ? S_DONE : S_IDLE);
      S_WAIT:  w_next = i_data_ok ? (i_flush ? S_IDLE : S_DONE) : (i_flush ? S_DRAIN : S_WAIT);
      S_DRAIN: w_next = i_data_ok ? S_IDLE : S_DRAIN;
      S_DONE:  w_next = (!i_longest_stall || i_flush) ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_illegal <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_wr      <= o_req ? w_wr : r_wr;
      r_illegal <= w_bad;
      r_rdata   <= w_load ? i_rdata : r_rdata;
    end
  end
endmodule

// File: tb/tb_sram2sraml_bridge.sv
// tb_sram2sraml_bridge: directed self-checking bench for the 32-bit read/write and 64-bit read-only bridges
module tb_sram2sraml_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0, longest = 1'b0, flush = 1'b0, addr_ok = 1'b0, data_ok = 1'b0;
  logic [3:0] wen = '0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [31:0] s_rdata, o_addr, o_wdata;
  logic stall, illegal, req, wr;
  logic [1:0] size;
  logic b_en = 1'b0, b_addr_ok = 1'b0, b_data_ok = 1'b0;
  logic [7:0] b_wen = '0;
  logic [31:0] b_addr = '0, b_oaddr;
  logic [63:0] b_wdata = '0, b_rdata = '0, b_srdata, b_owdata;
  logic b_stall, b_illegal, b_req, b_wr;
  logic [1:0] b_size;
  int checks = 0;
  int errors = 0;
  logic [3:0] tbl_wen [4] = '{4'b0001, 4'b0100, 4'b1100, 4'b1111};
  logic [1:0] tbl_size [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
  logic [31:0] tbl_addr [4] = '{32'h1000_0004, 32'h1000_0006, 32'h1000_0006, 32'h1000_0004};

  always #5 clk = ~clk;

  sram2sraml_bridge #(.DATA_W(32), .ADDR_W(32), .WRITE_EN(1)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_sram_en(en), .i_sram_wen(wen), .i_sram_addr(addr),
    .i_sram_wdata(wdata), .o_sram_rdata(s_rdata), .o_stall(stall), .i_longest_stall(longest),
    .i_flush(flush), .o_illegal_wen(illegal), .o_req(req), .o_wr(wr), .o_size(size),
    .o_addr(o_addr), .o_wdata(o_wdata), .i_addr_ok(addr_ok), .i_data_ok(data_ok), .i_rdata(rdata)
  );

  sram2sraml_bridge #(.DATA_W(64), .ADDR_W(32), .WRITE_EN(0)) dut_b (
    .i_clk(clk), .i_resetn(resetn), .i_sram_en(b_en), .i_sram_wen(b_wen), .i_sram_addr(b_addr),
    .i_sram_wdata(b_wdata), .o_sram_rdata(b_srdata), .o_stall(b_stall), .i_longest_stall(1'b0),
    .i_flush(1'b0), .o_illegal_wen(b_illegal), .o_req(b_req), .o_wr(b_wr), .o_size(b_size),
    .o_addr(b_oaddr), .o_wdata(b_owdata), .i_addr_ok(b_addr_ok), .i_data_ok(b_data_ok), .i_rdata(b_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_rdata", s_rdata, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_stall", stall, 0);
    #11 resetn = 1'b1;
    // read: addr_ok on first request cycle, data_ok two cycles later
    tick();
    en = 1; addr = 32'h2000_0008; addr_ok = 1;
    #1;
    chk("rd_req", req, 1);
    chk("rd_wr", wr, 0);
    chk("rd_size", size, 2);
    chk("rd_addr", o_addr, 32'h2000_0008);
    chk("rd_stall0", stall, 1);
    tick();
    addr_ok = 0;
    #1;
    chk("rd_req_wait", req, 0);
    chk("rd_stall1", stall, 1);
    tick();
    data_ok = 1; rdata = 32'hDEAD_BEEF; longest = 1;
    #1;
    chk("rd_stall2", stall, 1);
    chk("rd_rdata_pre", s_rdata, 0);
    tick();
    data_ok = 0; rdata = 0;
    #1;
    chk("rd_stall_done", stall, 0);
    chk("rd_rdata", s_rdata, 32'hDEAD_BEEF);
    tick();
    chk("rd_hold", stall, 0);
    longest = 0;
    #1;
    chk("rd_hold_drop", stall, 0);
    tick();
    chk("rd_idle_stall", stall, 1);
    chk("rd_idle_req", req, 1);
    en = 0;
    // same-cycle addr_ok and data_ok
    tick();
    en = 1; addr_ok = 1; data_ok = 1; rdata = 32'hCAFE_F00D;
    #1;
    chk("sc_req", req, 1);
    chk("sc_stall", stall, 1);
    tick();
    addr_ok = 0; data_ok = 0; rdata = 0;
    #1;
    chk("sc_stall_drop", stall, 0);
    chk("sc_rdata", s_rdata, 32'hCAFE_F00D);
    tick();
    chk("sc_idle", stall, 1);
    en = 0;
    // write halfword at offset 2
    tick();
    en = 1; wen = 4'b1100; addr = 32'h1000_0004; wdata = 32'hAABB_0000;
    addr_ok = 1; data_ok = 1; rdata = 32'h1111_1111;
    #1;
    chk("wr_req", req, 1);
    chk("wr_wr", wr, 1);
    chk("wr_size", size, 1);
    chk("wr_addr", o_addr, 32'h1000_0006);
    chk("wr_wdata", o_wdata, 32'hAABB_0000);
    tick();
    addr_ok = 0; data_ok = 0; rdata = 0;
    #1;
    chk("wr_rdata_kept", s_rdata, 32'hCAFE_F00D);
    chk("wr_stall", stall, 0);
    en = 0; wen = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      en = 1; wen = tbl_wen[i];
      #1;
      chk("tbl_req", req, 1);
      chk("tbl_size", size, tbl_size[i]);
      chk("tbl_addr", o_addr, tbl_addr[i]);
    end
    en = 0; wen = 0;
    // illegal strobe
    tick();
    en = 1; wen = 4'b0110;
    #1;
    chk("ill_req", req, 0);
    chk("ill_stall", stall, 1);
    chk("ill_pulse_pre", illegal, 0);
    tick();
    chk("ill_pulse", illegal, 1);
    chk("ill_release", stall, 0);
    en = 0; wen = 0;
    tick();
    chk("ill_pulse_end", illegal, 0);
    // flush in WAIT before data_ok -> DRAIN
    en = 1; addr = 32'h2000_0008; addr_ok = 1;
    tick();
    addr_ok = 0; flush = 1;
    #1;
    chk("fl_stall", stall, 0);
    chk("fl_req", req, 0);
    tick();
    flush = 0;
    #1;
    chk("dr_req", req, 0);
    chk("dr_stall", stall, 1);
    tick();
    data_ok = 1; rdata = 32'h1234_5678;
    #1;
    chk("dr_req2", req, 0);
    tick();
    data_ok = 0; rdata = 0;
    #1;
    chk("dr_rdata_kept", s_rdata, 32'hCAFE_F00D);
    chk("dr_idle_req", req, 1);
    en = 0;
    // flush together with data_ok in WAIT
    tick();
    en = 1; addr_ok = 1;
    tick();
    addr_ok = 0; flush = 1; data_ok = 1; rdata = 32'h5555_5555;
    tick();
    flush = 0; data_ok = 0; rdata = 0;
    #1;
    chk("fd_rdata_kept", s_rdata, 32'hCAFE_F00D);
    chk("fd_idle_req", req, 1);
    en = 0;
    // asynchronous reset while in WAIT
    tick();
    en = 1; addr_ok = 1;
    tick();
    addr_ok = 0;
    #1;
    chk("ar_wait_req", req, 0);
    #2 resetn = 0;
    #1;
    chk("ar_req_idle", req, 1);
    chk("ar_rdata", s_rdata, 0);
    chk("ar_illegal", illegal, 0);
    #2 resetn = 1;
    en = 0;
    // 64-bit read-only instance
    tick();
    b_en = 1; b_wen = 8'hFF; b_addr = 32'h3000_0013; b_wdata = 64'h1122_3344_5566_7788;
    b_addr_ok = 1; b_data_ok = 1; b_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("b_req", b_req, 1);
    chk("b_wr", b_wr, 0);
    chk("b_size", b_size, 3);
    chk("b_addr", b_oaddr, 32'h3000_0013);
    chk("b_wdata", b_owdata, 0);
    tick();
    b_addr_ok = 0; b_data_ok = 0; b_rdata = 0;
    #1;
    chk("b_rdata", b_srdata, 64'h0123_4567_89AB_CDEF);
    chk("b_stall", b_stall, 0);
    b_en = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram2sraml_bridge.md
Name: sram2sraml_bridge

Overview:
- Parametrised bridge from a CPU-side SRAM-style port (single-cycle view, stall-based) to an SRAM-like split-handshake bus (req/addr_ok, then data_ok).
- One instance serves the instruction side (WRITE_EN=0). Another serves the data side (WRITE_EN=1).
- Adds write support with strobe-to-size/offset conversion, configurable data width, and a flush/drain mode for abandoned transactions.
- Sits between the pipeline stage that owns the memory port and the SRAM-like-to-AXI converter.

Parameters:
- DATA_W, 32, bus data width in bits; legal values 32 or 64.
- ADDR_W, 32, address width.
- WRITE_EN, 1, 1 = read and write path; 0 = read-only: sram_wen ignored, wr tied 0, wdata tied 0.
- STRB_W, DATA_W/8, byte-strobe width (derived, not overridden).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous reset, active-low.
- sram_en  in  1  access request from pipeline.
- sram_wen  in  STRB_W  byte write strobes; all zero = read.
- sram_addr  in  ADDR_W  byte address.
- sram_wdata  in  DATA_W  write data, byte-lane aligned.
- sram_rdata  out  DATA_W  captured read data.
- stall  out  1  pipeline stall for this port.
- longest_stall  in  1  global stall; completed result is held while high.
- flush  in  1  abandon current access (exception/branch flush).
- illegal_wen  out  1  one-cycle pulse: non-encodable strobe pattern rejected.
- req  out  1  SRAM-like request.
- wr  out  1  1 = write.
- size  out  2  log2(bytes).
- addr  out  ADDR_W  request address.
- wdata  out  DATA_W  request write data.
- addr_ok  in  1  address handshake.
- data_ok  in  1  data handshake.
- rdata  in  DATA_W  read return data.

Behaviour:
- States: IDLE, WAIT_DATA, DONE, DRAIN. Async reset: state=IDLE, sram_rdata=0, illegal_wen=0.
- req = sram_en & (state==IDLE) & ~flush & legal. In every other state req=0.
- IDLE:
  - req & addr_ok & data_ok -> DONE (data_ok takes priority).
  - req & addr_ok -> WAIT_DATA.
  - Otherwise stay.
- WAIT_DATA:
  - data_ok -> DONE.
  - flush & ~data_ok -> DRAIN.
  - flush & data_ok -> IDLE; the returned data is discarded.
- DRAIN: req=0; data_ok -> IDLE; data is discarded.
- DONE:
  - ~longest_stall -> IDLE.
  - flush -> IDLE.
  - Otherwise hold.
- stall = sram_en & (state!=DONE) & ~flush. Combinational; no added latency beyond the bus.
- sram_rdata loads rdata on data_ok of a read in IDLE or WAIT_DATA. It is unchanged on writes and in DRAIN.
- Reads:
  - wr=0.
  - size=log2(STRB_W): 2 for 32-bit, 3 for 64-bit.
  - addr=sram_addr unmodified.
- Writes (WRITE_EN=1, wen!=0):
  - wr=1; wdata=sram_wdata.
  - Strobe must be one contiguous naturally-aligned group of 1, 2, 4 or 8 bytes.
  - size=log2(count).
  - addr = {sram_addr[ADDR_W-1:log2(STRB_W)], byte offset of lowest set strobe}.
  - Example 32-bit: 0001->size0/off0, 0100->size0/off2, 1100->size1/off2, 1111->size2/off0, 0110->illegal.
- Illegal strobe in IDLE with sram_en and no flush:
  - No req issued.
  - illegal_wen pulses 1 cycle.
  - State -> DONE, so the pipeline is released with no memory effect.
- addr_ok without req, or data_ok in IDLE with no req: ignored. No state change.
- Request inputs are not registered; the pipeline holds them stable while stall=1.
- Async reset mid-transaction returns to IDLE immediately. Any in-flight response is the downstream's responsibility, because the downstream is reset by the same resetn.

Decomposition:
- Package sraml_pkg holds:
  - State enum constants S_IDLE/S_WAIT/S_DONE/S_DRAIN (2-bit).
  - SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2, SIZE_DWORD=3.
  - Function clog2.
- One combinational sub-module, sraml_wen2size:
  - Input: STRB_W strobe.
  - Outputs: size, offset, legal.
  - Parametrised on STRB_W; verified standalone by exhaustive strobe sweep.

Test Plan:
- Read, addr_ok cycle 1, data_ok cycle 3, rdata=0xDEADBEEF -> req high 1 cycle; stall high cycles 0-3; sram_rdata=0xDEADBEEF from cycle 4; DONE held while longest_stall=1, IDLE one cycle after it drops.
- Same-cycle addr_ok&data_ok on read -> direct IDLE->DONE; stall drops the next cycle; no WAIT_DATA visit.
- Write wen=4'b1100, addr=0x1000_0004, 32-bit -> req with wr=1, size=1, addr=0x1000_0006; sram_rdata unchanged.
- wen=4'b0110 -> req never asserted; illegal_wen pulses once; stall released the following cycle.
- Flush in WAIT_DATA before data_ok, data_ok 2 cycles later with rdata=0x12345678 -> DRAIN; no req during DRAIN; sram_rdata keeps its old value; new req only after return to IDLE.
- resetn low during WAIT_DATA -> state IDLE and outputs zero immediately (asynchronous); WRITE_EN=0 and DATA_W=64 build: wen=0xFF read -> wr=0, size=3.
